// File: rtl/alarm_trigger_pkg.sv
// Shared definitions for the alarm trigger: FSM state encoding, key codes and the
// layout of the packed 52-bit time/alarm word {year, month, day, hour, minute, second}.
package alarm_trigger_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } state_e;

    localparam logic [3:0] KEY_DISMISS = 4'b0001;
    localparam logic [3:0] KEY_SNOOZE  = 4'b0010;

    // Packed time word layout, LSB first.
    localparam int unsigned YearW   = 12;
    localparam int unsigned FieldW  = 8;
    localparam int unsigned AlarmW  = YearW + 5 * FieldW;
    localparam int unsigned SecOff  = 0;
    localparam int unsigned MinOff  = 8;
    localparam int unsigned HourOff = 16;
    localparam int unsigned DayOff  = 24;
    localparam int unsigned MonOff  = 32;
    localparam int unsigned YearOff = 40;

    // Builds a time word in the same order as bin_alarm.
    function automatic logic [AlarmW-1:0] pack_time(
        input logic [YearW-1:0]  yr,
        input logic [FieldW-1:0] mo,
        input logic [FieldW-1:0] dy,
        input logic [FieldW-1:0] hr,
        input logic [FieldW-1:0] mi,
        input logic [FieldW-1:0] se
    );
        logic [AlarmW-1:0] t;
        t = '0;
        t[YearOff +: YearW] = yr;
        t[MonOff  +: FieldW] = mo;
        t[DayOff  +: FieldW] = dy;
        t[HourOff +: FieldW] = hr;
        t[MinOff  +: FieldW] = mi;
        t[SecOff  +: FieldW] = se;
        return t;
    endfunction

endpackage

// File: rtl/alarm_trigger_tick_edge.sv
// tick_edge: brings the asynchronous 1 Hz square wave into the clk domain through a
// 2-flop synchroniser and emits a one-clk pulse on each rising edge.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears all flops
//   in    - asynchronous 1 Hz input
//   pulse - one-clk pulse per rising edge of in
module tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: compares the current time against a stored alarm, rings with a
// toggling buzzer, supports a limited number of snoozes and auto-stops after RING_SEC
// ticks. Finishing an alarm (dismiss or timeout) pulses rst_alarm so the setting
// logic upstream can clear the stored alarm.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   clk1sec             - 1 Hz square wave, rising edge is one tick
//   sw_in               - key code (0001 dismiss, 0010 snooze)
//   bin_alarm           - alarm target, all-zero means no alarm
//   year..second        - current time fields
//   rst_alarm           - one-clk request to clear the stored alarm
//   ring, buzzer        - ringing indication and beep drive
//   snoozing            - high while snoozing
//   snooze_left         - ticks remaining in the current snooze
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk1sec,
    input  logic [3:0]        sw_in,
    input  logic [AlarmW-1:0] bin_alarm,
    input  logic [YearW-1:0]  year,
    input  logic [FieldW-1:0] month,
    input  logic [FieldW-1:0] day,
    input  logic [FieldW-1:0] hour,
    input  logic [FieldW-1:0] minute,
    input  logic [FieldW-1:0] second,
    output logic              rst_alarm,
    output logic              ring,
    output logic              buzzer,
    output logic              snoozing,
    output logic [8:0]        snooze_left
);

    localparam int unsigned RingW = (RING_SEC < 1) ? 1 : $clog2(RING_SEC + 1);
    localparam int unsigned SnzW  = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam logic [8:0]  SnoozeLoad = 9'(SNOOZE_SEC);

    state_e            state_q, state_d;
    logic [RingW-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SnzW-1:0]   snz_cnt_q, snz_cnt_d;
    logic [8:0]        snooze_left_q, snooze_left_d;
    logic              ring_q, ring_d;
    logic              buzzer_q, buzzer_d;
    logic              snoozing_q, snoozing_d;
    logic              rst_alarm_q, rst_alarm_d;

    logic              tick;
    logic [AlarmW-1:0] now;
    logic              alarm_set, alarm_now;
    logic              key_dismiss, key_snooze, tick_eff;
    logic              snz_avail, ring_done, enter_ring;

    tick_edge u_tick (
        .clk   (clk),
        .rst   (rst),
        .in    (clk1sec),
        .pulse (tick)
    );

    assign now         = pack_time(year, month, day, hour, minute, second);
    assign alarm_set   = (bin_alarm != '0);
    assign alarm_now   = (bin_alarm == now);
    assign key_dismiss = (sw_in == KEY_DISMISS);
    assign key_snooze  = (sw_in == KEY_SNOOZE);
    // A valid key on the same clk as a tick consumes that tick.
    assign tick_eff    = tick & ~(key_dismiss | key_snooze);
    assign snz_avail   = (snz_cnt_q < SnzW'(MAX_SNOOZE));
    assign ring_done   = (ring_cnt_q == RingW'(RING_SEC));

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snooze_left_q <= '0;
            ring_q        <= 1'b0;
            buzzer_q      <= 1'b0;
            snoozing_q    <= 1'b0;
            rst_alarm_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snooze_left_q <= snooze_left_d;
            ring_q        <= ring_d;
            buzzer_q      <= buzzer_d;
            snoozing_q    <= snoozing_d;
            rst_alarm_q   <= rst_alarm_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // alarm_now blocks re-arming in the same second after a dismiss.
                if (alarm_set && !alarm_now) state_d = StArmed;
            end
            StArmed: begin
                if (!alarm_set)     state_d = StIdle;
                else if (alarm_now) state_d = StRinging;
            end
            StRinging: begin
                if (!alarm_set || key_dismiss) state_d = StIdle;
                else if (key_snooze)           state_d = snz_avail ? StSnooze : StIdle;
                else if (ring_done)            state_d = StIdle;
            end
            StSnooze: begin
                if (!alarm_set || key_dismiss)               state_d = StIdle;
                else if (tick_eff && snooze_left_q == 9'd1)  state_d = StRinging;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and counter next-state logic, derived from the transition taken.
    always_comb begin
        ring_d        = (state_d == StRinging);
        snoozing_d    = (state_d == StSnooze);
        enter_ring    = ring_d && (state_q != StRinging);
        // Finishing an alarm asks upstream to clear it; a cleared alarm needs no request.
        rst_alarm_d   = (state_d == StIdle) && alarm_set &&
                        (state_q == StRinging || state_q == StSnooze);

        buzzer_d      = 1'b0;
        ring_cnt_d    = '0;
        if (enter_ring) begin
            buzzer_d   = 1'b1;
            ring_cnt_d = '0;
        end else if (ring_d) begin
            buzzer_d   = buzzer_q ^ tick_eff;
            ring_cnt_d = ring_cnt_q + RingW'(tick_eff);
        end

        snooze_left_d = '0;
        if (snoozing_d) begin
            if (state_q != StSnooze) snooze_left_d = SnoozeLoad;
            else if (tick_eff)       snooze_left_d = snooze_left_q - 9'd1;
            else                     snooze_left_d = snooze_left_q;
        end

        snz_cnt_d = snz_cnt_q;
        if (state_d == StIdle) begin
            snz_cnt_d = '0;
        end else if (state_q == StRinging && state_d == StSnooze) begin
            snz_cnt_d = snz_cnt_q + SnzW'(1);
        end
    end

    assign rst_alarm   = rst_alarm_q;
    assign ring        = ring_q;
    assign buzzer      = buzzer_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = snooze_left_q;

endmodule
